serial_tx: RTL and testbench

SERIAL_TX -- requirements
Module: serial_tx

---
 rtl/serial_pkg.sv | 30 +++
 rtl/serial_tx_if.sv | 11 +
 rtl/serial_tx_baud_tick.sv | 39 +++
 rtl/serial_tx.sv | 147 ++++++++++++++
 tb/tb_serial_tx.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/serial_pkg.sv
// Shared types and constants for the serial transmitter: FSM states, parity
// modes, default bit period and the parity helper.
package serial_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 434;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        EVEN = 2'd1,
        ODD  = 2'd2
    } parity_t;

    function automatic logic parity_bit(input logic [7:0] data, input parity_t mode);
        logic p;
        p = ^data;
        case (mode)
            ODD:     return ~p;
            default: return p;
        endcase
    endfunction

endpackage

// File: rtl/serial_tx_if.sv
// Byte-request / serial-line bundle between a transmitter client (master)
// and the serial_tx block (slave).
interface serial_tx_if;
    logic       txStart;
    logic [7:0] txData;
    logic       txBusy;
    logic       txd;

    modport master (output txStart, output txData, input txBusy, input txd);
    modport slave  (input txStart, input txData, output txBusy, output txd);
endinterface

// File: rtl/serial_tx_baud_tick.sv
// Bit-period timer: reloadable down-counter that pulses tick on the last
// cycle of every bit so the FSM advances exactly on bit boundaries.
module baud_tick #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    input  logic enable,
    output logic tick
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] ZERO   = CW'(0);
    localparam logic [CW-1:0] ONE    = CW'(1);

    logic [CW-1:0] cnt_r;

    // Down-counter: reload on restart and at each boundary so no drift accumulates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= ZERO;
        end else if (restart) begin
            cnt_r <= RELOAD;
        end else if (enable) begin
            if (cnt_r == ZERO) begin
                cnt_r <= RELOAD;
            end else begin
                cnt_r <= cnt_r - ONE;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign tick = enable && (cnt_r == ZERO);

endmodule

// File: rtl/serial_tx.sv
// UART-style transmitter: frame FSM, LSB-first shift register and optional
// parity; bit timing comes from baud_tick.
module serial_tx
    import serial_pkg::*;
#(
    parameter int      CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter parity_t PARITY       = NONE,
    parameter int      STOP_BITS    = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    serial_tx_if.slave  bus
);

    tx_state_t  state_r;
    tx_state_t  state_next_s;
    logic [7:0] shift_r;
    logic [7:0] shift_next_s;
    logic       parity_r;
    logic       parity_next_s;
    logic [2:0] bit_idx_r;
    logic [2:0] bit_idx_next_s;
    logic       stop_idx_r;
    logic       stop_idx_next_s;
    logic       txd_r;
    logic       txd_next_s;
    logic       busy_r;
    logic       busy_next_s;
    logic       accept_s;
    logic       tick_s;
    logic       last_data_s;
    logic       last_stop_s;

    assign accept_s    = bus.txStart && !busy_r && (state_r == ST_IDLE);
    assign last_data_s = (bit_idx_r == 3'd7);
    assign last_stop_s = (STOP_BITS == 1) || stop_idx_r;

    baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud_tick (
        .clk     (clk),
        .rst_n   (reset_n),
        .restart (accept_s),
        .enable  (busy_r),
        .tick    (tick_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: every non-idle state advances only on a bit tick.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_next_s = ST_START;
                else          state_next_s = ST_IDLE;
            end
            ST_START: begin
                if (tick_s) state_next_s = ST_DATA;
                else        state_next_s = ST_START;
            end
            ST_DATA: begin
                if (tick_s && last_data_s) state_next_s = (PARITY != NONE) ? ST_PARITY : ST_STOP;
                else                       state_next_s = ST_DATA;
            end
            ST_PARITY: begin
                if (tick_s) state_next_s = ST_STOP;
                else        state_next_s = ST_PARITY;
            end
            ST_STOP: begin
                if (tick_s && last_stop_s) state_next_s = ST_IDLE;
                else                       state_next_s = ST_STOP;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Datapath next values: capture on acceptance, shift and count on bit ticks.
    always_comb begin
        shift_next_s    = shift_r;
        parity_next_s   = parity_r;
        bit_idx_next_s  = bit_idx_r;
        stop_idx_next_s = stop_idx_r;
        if (accept_s) begin
            shift_next_s    = bus.txData;
            parity_next_s   = parity_bit(bus.txData, PARITY);
            bit_idx_next_s  = 3'd0;
            stop_idx_next_s = 1'b0;
        end else if (tick_s && (state_r == ST_DATA)) begin
            shift_next_s   = {1'b0, shift_r[7:1]};
            bit_idx_next_s = bit_idx_r + 3'd1;
        end else if (tick_s && (state_r == ST_STOP)) begin
            stop_idx_next_s = ~stop_idx_r;
        end else begin
            shift_next_s = shift_r;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_r    <= 8'd0;
            parity_r   <= 1'b0;
            bit_idx_r  <= 3'd0;
            stop_idx_r <= 1'b0;
        end else begin
            shift_r    <= shift_next_s;
            parity_r   <= parity_next_s;
            bit_idx_r  <= bit_idx_next_s;
            stop_idx_r <= stop_idx_next_s;
        end
    end

    // Output decode from the upcoming state so the registered line switches on the boundary edge.
    always_comb begin
        txd_next_s  = 1'b1;
        busy_next_s = 1'b0;
        case (state_next_s)
            ST_IDLE:   begin txd_next_s = 1'b1;            busy_next_s = 1'b0; end
            ST_START:  begin txd_next_s = 1'b0;            busy_next_s = 1'b1; end
            ST_DATA:   begin txd_next_s = shift_next_s[0]; busy_next_s = 1'b1; end
            ST_PARITY: begin txd_next_s = parity_r;        busy_next_s = 1'b1; end
            ST_STOP:   begin txd_next_s = 1'b1;            busy_next_s = 1'b1; end
            default:   begin txd_next_s = 1'b1;            busy_next_s = 1'b0; end
        endcase
    end

    // Registered line and busy flag; the line idles high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            txd_r  <= 1'b1;
            busy_r <= 1'b0;
        end else begin
            txd_r  <= txd_next_s;
            busy_r <= busy_next_s;
        end
    end

    assign bus.txd    = txd_r;
    assign bus.txBusy = busy_r;

endmodule

// File: tb/tb_serial_tx.sv
// Scoreboard bench for serial_tx at 4 clocks/bit: four configurations, a
// receiver-model monitor per instance checking bit timing, framing and data.
module tb_serial_tx;
    import serial_pkg::*;

    typedef struct packed {
        logic [1:0] inst;
        logic [7:0] data;
        logic       has_par;
        logic       par;
        logic [1:0] nstop;
        logic       abort;
    } exp_t;

    logic       clk;
    logic       reset_n;
    logic [3:0] start_s;
    logic [7:0] data_s [4];
    logic [3:0] busy_w;
    logic [3:0] txd_w;
    exp_t       sb [$];
    int         n_chk;
    int         n_pass;

    serial_tx_if if_0 ();
    serial_tx_if if_1 ();
    serial_tx_if if_2 ();
    serial_tx_if if_3 ();

    assign if_0.txStart = start_s[0];
    assign if_1.txStart = start_s[1];
    assign if_2.txStart = start_s[2];
    assign if_3.txStart = start_s[3];
    assign if_0.txData  = data_s[0];
    assign if_1.txData  = data_s[1];
    assign if_2.txData  = data_s[2];
    assign if_3.txData  = data_s[3];
    assign busy_w = {if_3.txBusy, if_2.txBusy, if_1.txBusy, if_0.txBusy};
    assign txd_w  = {if_3.txd, if_2.txd, if_1.txd, if_0.txd};

    serial_tx #(.CLKS_PER_BIT(4), .PARITY(NONE), .STOP_BITS(1)) u_dut0 (.clk(clk), .reset_n(reset_n), .bus(if_0));
    serial_tx #(.CLKS_PER_BIT(4), .PARITY(EVEN), .STOP_BITS(1)) u_dut1 (.clk(clk), .reset_n(reset_n), .bus(if_1));
    serial_tx #(.CLKS_PER_BIT(4), .PARITY(ODD),  .STOP_BITS(1)) u_dut2 (.clk(clk), .reset_n(reset_n), .bus(if_2));
    serial_tx #(.CLKS_PER_BIT(4), .PARITY(NONE), .STOP_BITS(2)) u_dut3 (.clk(clk), .reset_n(reset_n), .bus(if_3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic send(input int k, input logic [7:0] d, input logic hp, input logic p,
                        input logic [1:0] ns, input logic ab);
        exp_t e;
        e.inst = 2'(k); e.data = d; e.has_par = hp; e.par = p; e.nstop = ns; e.abort = ab;
        sb.push_back(e);
        @(negedge clk);
        start_s[k] = 1'b1;
        data_s[k]  = d;
        @(negedge clk);
        start_s[k] = 1'b0;
        data_s[k]  = ~d;
    endtask

    task automatic wait_idle(input int k);
        int i;
        i = 0;
        while (busy_w[k] === 1'b1 && i < 100) begin
            @(negedge clk);
            i++;
        end
        check("idle_timeout", 32'(busy_w[k]), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic quiet_window(input int k, input int cycles, input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (busy_w[k] !== 1'b0) seen = 1'b1;
        end
        check(name, 32'(seen), 32'd0);
    endtask

    // Receiver model: capture the line for every busy cycle, then judge the frame.
    task automatic monitor(input int k);
        exp_t       e;
        logic       line [64];
        int         n;
        int         nb;
        logic       rs;
        logic       b;
        logic [3:0] smp;
        logic [7:0] rx;
        forever begin
            @(negedge clk);
            if (busy_w[k] === 1'b1) begin
                n  = 0;
                rs = 1'b0;
                while (busy_w[k] === 1'b1 && n < 64) begin
                    line[n] = txd_w[k];
                    n++;
                    @(negedge clk);
                    if (reset_n === 1'b0) rs = 1'b1;
                end
                if (sb.size() == 0) begin
                    check("frame_expected", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    check("instance", 32'(k), 32'(e.inst));
                    check("abort", 32'(rs), 32'(e.abort));
                    if (!rs) begin
                        nb = 9 + int'(e.has_par) + int'(e.nstop);
                        check("busy_len", 32'(n), 32'(4 * nb));
                        for (int i = 0; i < nb; i++) begin
                            if (i == 0)                     b = 1'b0;
                            else if (i <= 8)                b = e.data[i-1];
                            else if (i == 9 && e.has_par)   b = e.par;
                            else                            b = 1'b1;
                            for (int j = 0; j < 4; j++) smp[j] = line[(4 * i + j) % 64];
                            check($sformatf("bit%0d", i), 32'(smp), 32'({4{b}}));
                        end
                        for (int j = 0; j < 8; j++) rx[j] = line[4 * (j + 1) + 2];
                        check("rx_byte", 32'(rx), 32'(e.data));
                    end
                end
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);
    initial monitor(2);
    initial monitor(3);

    initial begin
        n_chk   = 0;
        n_pass  = 0;
        reset_n = 1'b0;
        start_s = 4'b0000;
        for (int i = 0; i < 4; i++) data_s[i] = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_txd", 32'(txd_w), 32'hF);
        check("reset_busy", 32'(busy_w), 32'h0);
        reset_n = 1'b1;

        // 8N1 0xA5
        send(0, 8'hA5, 1'b0, 1'b0, 2'd1, 1'b0);
        wait_idle(0);
        // Parity 0x07: even -> 1, odd -> 0
        send(1, 8'h07, 1'b1, 1'b1, 2'd1, 1'b0);
        wait_idle(1);
        send(2, 8'h07, 1'b1, 1'b0, 2'd1, 1'b0);
        wait_idle(2);
        // Two stop bits
        send(3, 8'h80, 1'b0, 1'b0, 2'd2, 1'b0);
        wait_idle(3);

        // Back-to-back 0x00 then 0xFF in the first idle cycle
        send(0, 8'h00, 1'b0, 1'b0, 2'd1, 1'b0);
        for (int i = 0; i < 100 && busy_w[0] === 1'b1; i++) @(negedge clk);
        check("b2b_first_idle_txd", 32'(txd_w[0]), 32'd1);
        sb.push_back('{inst: 2'd0, data: 8'hFF, has_par: 1'b0, par: 1'b0, nstop: 2'd1, abort: 1'b0});
        start_s[0] = 1'b1;
        data_s[0]  = 8'hFF;
        @(negedge clk);
        start_s[0] = 1'b0;
        data_s[0]  = 8'h00;
        check("b2b_accept_busy", 32'(busy_w[0]), 32'd1);
        check("b2b_start_bit", 32'(txd_w[0]), 32'd0);
        wait_idle(0);

        // Requests during a frame are ignored
        send(0, 8'hC3, 1'b0, 1'b0, 2'd1, 1'b0);
        repeat (4) @(negedge clk);
        start_s[0] = 1'b1; data_s[0] = 8'h11;
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (14) @(negedge clk);
        start_s[0] = 1'b1; data_s[0] = 8'h11;
        @(negedge clk);
        start_s[0] = 1'b0;
        wait_idle(0);
        quiet_window(0, 20, "no_queued_frame");

        // Mid-frame reset aborts 0x3C
        send(0, 8'h3C, 1'b0, 1'b0, 2'd1, 1'b1);
        repeat (17) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_txd", 32'(txd_w[0]), 32'd1);
        check("async_reset_busy", 32'(busy_w[0]), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        quiet_window(0, 50, "no_resend");
        send(0, 8'h42, 1'b0, 1'b0, 2'd1, 1'b0);
        wait_idle(0);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
